fifo_level: RTL and testbench

- Parametrised synchronous single-clock FIFO; next generation of the image-pipeline buffer.
- Adds over the current buffer:
  - occupancy count
  - programmable almost-full / almost-empty flags
  - synchronous clear
  - overflow / underflow error pulses
  - defined simultaneous read/write at the full and empty boundaries
- Sits between the pixel producer and the processing stages. Upstream throttles on almost_full; downstream prefetches on almost_empty.

---
 rtl/fifo_level.sv | 94 +++++++++
 tb/tb_fifo_level.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fifo_level.sv
// Show-ahead single-clock FIFO with occupancy count, programmable almost flags and error pulses.
// Zero read latency on r_data; flags and level are registered from the next-level value.
module fifo_level #(
  parameter int B        = 8,
  parameter int W        = 8,
  parameter int AF_LEVEL = 2**W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);

  localparam int       D      = 2**W;
  localparam logic [W:0] L_FULL = {1'b1, {W{1'b0}}};
  localparam logic [W:0] L_AF   = AF_LEVEL[W:0];
  localparam logic [W:0] L_AE   = AE_LEVEL[W:0];

  logic [B-1:0] r_mem [D];
  logic [W-1:0] r_wptr;
  logic [W-1:0] r_rptr;
  logic [W:0]   r_level;
  logic         r_empty;
  logic         r_full;
  logic         r_almost_empty;
  logic         r_almost_full;
  logic         r_overflow;
  logic         r_underflow;

  logic         w_flush;
  logic         w_wr_ok;
  logic         w_rd_ok;
  logic [W:0]   w_level_nxt;

  // A write into a full FIFO is allowed when the head is popped on the same edge.
  always_comb begin
    w_flush     = reset | clr;
    w_wr_ok     = wr & (~r_full | rd);
    w_rd_ok     = rd & ~r_empty;
    w_level_nxt = r_level;
    if (w_flush)
      w_level_nxt = '0;
    else if (w_wr_ok & ~w_rd_ok)
      w_level_nxt = r_level + (W+1)'(1);
    else if (w_rd_ok & ~w_wr_ok)
      w_level_nxt = r_level - (W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + W'(1);
      if (w_rd_ok) r_rptr <= r_rptr + W'(1);
      r_overflow  <= wr & ~w_wr_ok;
      r_underflow <= rd & ~w_rd_ok;
    end
    r_level        <= w_level_nxt;
    r_empty        <= (w_level_nxt == '0);
    r_full         <= (w_level_nxt == L_FULL);
    r_almost_empty <= (w_level_nxt <= L_AE);
    r_almost_full  <= (w_level_nxt >= L_AF);
  end

  // Storage is intentionally not cleared by reset or clr.
  always_ff @(posedge clk) begin
    if (w_wr_ok & ~w_flush)
      r_mem[r_wptr] <= w_data;
  end

  assign r_data       = r_mem[r_rptr];
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign level        = r_level;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Directed table-driven bench for fifo_level with D=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_level;

  logic       clk = 1'b0;
  logic       reset, clr, wr, rd;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  fifo_level #(.B(8), .W(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, clr, wr, rd;
    logic [7:0] wd;
    logic [2:0] lvl;
    logic       e, f, ae, af, ov, un;
    logic       cd;
    logic [7:0] rdat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, input logic cl, input logic w, input logic r, input logic [7:0] wd,
                     input logic [2:0] lv, input logic e, input logic f, input logic ae, input logic af,
                     input logic ov, input logic un, input logic cd, input logic [7:0] rdat);
    vec_t v;
    v.rst = rs; v.clr = cl; v.wr = w; v.rd = r; v.wd = wd;
    v.lvl = lv; v.e = e; v.f = f; v.ae = ae; v.af = af; v.ov = ov; v.un = un;
    v.cd = cd; v.rdat = rdat;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rs, input logic cl, input logic w, input logic r, input logic [7:0] wd);
    @(negedge clk);
    reset = rs; clr = cl; wr = w; rd = r; w_data = wd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] status();
    return {7'd0, level, empty, full, almost_empty, almost_full, overflow, underflow};
  endfunction

  initial begin
    logic [7:0] a, b;
    reset = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;

    //   rst clr wr rd  wd      lvl  e  f  ae af ov un  cd data
    add(1, 0, 0, 0, 8'h00, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'h11, 3'd1, 0, 0, 1, 0, 0, 0, 1, 8'h11);
    add(0, 0, 1, 0, 8'h22, 3'd2, 0, 0, 0, 0, 0, 0, 1, 8'h11);
    add(0, 0, 1, 0, 8'h33, 3'd3, 0, 0, 0, 1, 0, 0, 1, 8'h11);
    add(0, 0, 1, 0, 8'h44, 3'd4, 0, 1, 0, 1, 0, 0, 1, 8'h11);
    add(0, 0, 1, 0, 8'h55, 3'd4, 0, 1, 0, 1, 1, 0, 1, 8'h11);
    add(0, 0, 0, 0, 8'h00, 3'd4, 0, 1, 0, 1, 0, 0, 1, 8'h11);
    add(0, 0, 0, 1, 8'h00, 3'd3, 0, 0, 0, 1, 0, 0, 1, 8'h22);
    add(0, 0, 0, 1, 8'h00, 3'd2, 0, 0, 0, 0, 0, 0, 1, 8'h33);
    add(0, 0, 0, 1, 8'h00, 3'd1, 0, 0, 1, 0, 0, 0, 1, 8'h44);
    add(0, 0, 0, 1, 8'h00, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    // refill, then simultaneous read/write while full
    add(0, 0, 1, 0, 8'h11, 3'd1, 0, 0, 1, 0, 0, 0, 1, 8'h11);
    add(0, 0, 1, 0, 8'h22, 3'd2, 0, 0, 0, 0, 0, 0, 1, 8'h11);
    add(0, 0, 1, 0, 8'h33, 3'd3, 0, 0, 0, 1, 0, 0, 1, 8'h11);
    add(0, 0, 1, 0, 8'h44, 3'd4, 0, 1, 0, 1, 0, 0, 1, 8'h11);
    add(0, 0, 1, 1, 8'h66, 3'd4, 0, 1, 0, 1, 0, 0, 1, 8'h22);
    add(0, 0, 0, 1, 8'h00, 3'd3, 0, 0, 0, 1, 0, 0, 1, 8'h33);
    add(0, 0, 0, 1, 8'h00, 3'd2, 0, 0, 0, 0, 0, 0, 1, 8'h44);
    add(0, 0, 0, 1, 8'h00, 3'd1, 0, 0, 1, 0, 0, 0, 1, 8'h66);
    add(0, 0, 0, 1, 8'h00, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    // empty boundary
    add(0, 0, 1, 1, 8'h77, 3'd1, 0, 0, 1, 0, 0, 1, 1, 8'h77);
    add(0, 0, 0, 1, 8'h00, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 1, 8'h00, 3'd0, 1, 0, 1, 0, 0, 1, 0, 8'h00);
    add(0, 0, 0, 0, 8'h00, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    // clr at level 3 with a concurrent write
    add(0, 0, 1, 0, 8'hA1, 3'd1, 0, 0, 1, 0, 0, 0, 1, 8'hA1);
    add(0, 0, 1, 0, 8'hA2, 3'd2, 0, 0, 0, 0, 0, 0, 1, 8'hA1);
    add(0, 0, 1, 0, 8'hA3, 3'd3, 0, 0, 0, 1, 0, 0, 1, 8'hA1);
    add(0, 1, 1, 0, 8'hB0, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 0, 8'h00, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'hC1, 3'd1, 0, 0, 1, 0, 0, 0, 1, 8'hC1);
    add(0, 0, 0, 1, 8'h00, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    // same with reset
    add(0, 0, 1, 0, 8'hD1, 3'd1, 0, 0, 1, 0, 0, 0, 1, 8'hD1);
    add(0, 0, 1, 0, 8'hD2, 3'd2, 0, 0, 0, 0, 0, 0, 1, 8'hD1);
    add(0, 0, 1, 0, 8'hD3, 3'd3, 0, 0, 0, 1, 0, 0, 1, 8'hD1);
    add(1, 0, 1, 1, 8'hE0, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 0, 8'h00, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'hF1, 3'd1, 0, 0, 1, 0, 0, 0, 1, 8'hF1);
    add(0, 0, 0, 1, 8'h00, 3'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].wd);
      check($sformatf("vec%0d status", i), status(),
            {7'd0, vecs[i].lvl, vecs[i].e, vecs[i].f, vecs[i].ae, vecs[i].af, vecs[i].ov, vecs[i].un});
      if (vecs[i].cd)
        check($sformatf("vec%0d r_data", i), {8'd0, r_data}, {8'd0, vecs[i].rdat});
    end

    // wrap-around: pointers cross D-1 -> 0 several times
    for (int r = 0; r < 10; r++) begin
      a = 8'(8'h80 + 2 * r);
      b = 8'(8'h81 + 2 * r);
      step(0, 0, 1, 0, a);
      step(0, 0, 1, 0, b);
      check($sformatf("wrap%0d lvl2", r), {13'd0, level}, 16'd2);
      check($sformatf("wrap%0d head0", r), {8'd0, r_data}, {8'd0, a});
      step(0, 0, 0, 1, 8'h00);
      check($sformatf("wrap%0d head1", r), {8'd0, r_data}, {8'd0, b});
      step(0, 0, 0, 1, 8'h00);
      check($sformatf("wrap%0d lvl0", r), {13'd0, level, empty}, 16'h0001);
    end

    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
